// File: rtl/filter_datapath_pkg.sv
// myfilter_pkg: command encoding, default widths and the shift-and-clip helper
// shared by the filter controller, datapath and benches.
package myfilter_pkg;
    localparam int NTAPS       = 5;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_COEFF_W = 16;
    localparam int DEF_ACC_W   = 40;
    localparam int DEF_FRAC_W  = 15;
    localparam int DEF_OUT_W   = 16;

    typedef enum logic [3:0] {
        CMD_NOP    = 4'd0,
        CMD_SHIFT  = 4'd1,
        CMD_TAP0F  = 4'd2,
        CMD_TAP0   = 4'd3,
        CMD_TAP1   = 4'd4,
        CMD_TAP2   = 4'd5,
        CMD_TAP3   = 4'd6,
        CMD_TAP4   = 4'd7,
        CMD_SAT_SH = 4'd8
    } dp_cmd_t;

    typedef struct packed {
        logic                 sat;
        logic [DEF_OUT_W-1:0] val;
    } sat_t;

    function automatic sat_t sat_f(input logic signed [DEF_ACC_W-1:0] acc);
        logic signed [DEF_ACC_W-1:0] s;
        logic hi, lo;
        s  = acc >>> DEF_FRAC_W;
        hi = !s[DEF_ACC_W-1] && (|s[DEF_ACC_W-2:DEF_OUT_W-1]);
        lo = s[DEF_ACC_W-1] && !(&s[DEF_ACC_W-2:DEF_OUT_W-1]);
        sat_f.sat = hi || lo;
        sat_f.val = hi ? {1'b0, {(DEF_OUT_W-1){1'b1}}} :
                    lo ? {1'b1, {(DEF_OUT_W-1){1'b0}}} : s[DEF_OUT_W-1:0];
    endfunction
endpackage

// File: rtl/filter_datapath_if.sv
// filter_datapath_if: command, sample, coefficient and result signals between
// the filter controller (master) and the datapath (slave).
interface filter_datapath_if
    import myfilter_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int COEFF_W = DEF_COEFF_W,
    parameter int OUT_W   = DEF_OUT_W
);
    dp_cmd_t            cmd_in;
    logic [DATA_W-1:0]  din_in;
    logic               coeff_we_in;
    logic [2:0]         coeff_addr_in;
    logic [COEFF_W-1:0] coeff_in;
    logic               din_ack_out;
    logic [OUT_W-1:0]   dout_out;
    logic               dout_valid_out;
    logic               sat_out;

    modport master (
        output cmd_in, din_in, coeff_we_in, coeff_addr_in, coeff_in,
        input  din_ack_out, dout_out, dout_valid_out, sat_out
    );
    modport slave (
        input  cmd_in, din_in, coeff_we_in, coeff_addr_in, coeff_in,
        output din_ack_out, dout_out, dout_valid_out, sat_out
    );
endinterface

// File: rtl/filter_datapath_mac.sv
// filter_mac: single-cycle multiply-accumulate holding the FIR accumulator;
// load starts a new sum, acc_en adds to it, wrapping modulo 2^ACC_W.
module filter_mac #(
    parameter int DATA_W  = 16,
    parameter int COEFF_W = 16,
    parameter int ACC_W   = 40
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic signed [DATA_W-1:0]  x,
    input  logic signed [COEFF_W-1:0] c,
    input  logic                      load,
    input  logic                      acc_en,
    output logic signed [ACC_W-1:0]   acc
);
    logic signed [DATA_W+COEFF_W-1:0] prod;
    logic signed [ACC_W-1:0]          prod_ext;

    assign prod     = x * c;
    assign prod_ext = ACC_W'(prod);

    always_ff @(posedge clk) begin
        if (!rst_n) acc <= '0;
        else if (load) acc <= prod_ext;
        else if (acc_en) acc <= acc + prod_ext;
    end
endmodule

// File: rtl/filter_datapath.sv
// filter_datapath: executes one controller command per cycle on a 5-tap FIR
// (delay line, coefficient file, MAC, saturating output register).
module filter_datapath
    import myfilter_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int COEFF_W = DEF_COEFF_W,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int FRAC_W  = DEF_FRAC_W,
    parameter int OUT_W   = DEF_OUT_W
) (
    input logic clk,
    input logic rst_n,
    filter_datapath_if.slave bus
);
    logic signed [DATA_W-1:0]  x [NTAPS];
    logic signed [COEFF_W-1:0] c [NTAPS];
    logic signed [ACC_W-1:0]   acc, s;
    logic [2:0] tap;
    logic load, acc_en, is_shift, is_sat, hi, lo;

    always_comb begin
        is_shift = bus.cmd_in == CMD_SHIFT;
        is_sat   = bus.cmd_in == CMD_SAT_SH;
        load     = bus.cmd_in == CMD_TAP0F;
        acc_en   = bus.cmd_in inside {CMD_TAP0, CMD_TAP1, CMD_TAP2, CMD_TAP3, CMD_TAP4};
        tap      = acc_en ? 3'(bus.cmd_in - CMD_TAP0) : 3'd0;
        s        = acc >>> FRAC_W;
        hi       = !s[ACC_W-1] && (|s[ACC_W-2:OUT_W-1]);
        lo       = s[ACC_W-1] && !(&s[ACC_W-2:OUT_W-1]);
    end

    // The MAC reads registered c, so a same-cycle write to c[k] is seen one tap later.
    filter_mac #(.DATA_W(DATA_W), .COEFF_W(COEFF_W), .ACC_W(ACC_W)) u_mac (
        .clk(clk), .rst_n(rst_n), .x(x[tap]), .c(c[tap]),
        .load(load), .acc_en(acc_en), .acc(acc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NTAPS; k++) begin
                x[k] <= '0;
                c[k] <= '0;
            end
            bus.din_ack_out    <= 1'b0;
            bus.dout_out       <= '0;
            bus.dout_valid_out <= 1'b0;
            bus.sat_out        <= 1'b0;
        end else begin
            if (is_shift) begin
                x[0] <= bus.din_in;
                for (int k = 1; k < NTAPS; k++) x[k] <= x[k-1];
            end
            if (bus.coeff_we_in && bus.coeff_addr_in < 3'(NTAPS)) c[bus.coeff_addr_in] <= bus.coeff_in;
            bus.din_ack_out    <= is_shift;
            bus.dout_valid_out <= is_sat;
            bus.sat_out        <= is_sat && (hi || lo);
            if (is_sat)
                bus.dout_out <= hi ? {1'b0, {(OUT_W-1){1'b1}}} :
                                lo ? {1'b1, {(OUT_W-1){1'b0}}} : s[OUT_W-1:0];
        end
    end
endmodule

// File: tb/tb_filter_datapath.sv
// tb_filter_datapath: table vectors, directed corner sequences and random
// traffic checked against an integer model of the FIR datapath.
module tb_filter_datapath;
    import myfilter_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    filter_datapath_if bus ();
    filter_datapath dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int total = 0;
    int bad = 0;

    longint xm [5];
    longint cm [5];
    longint accm = 0;
    logic [15:0] edout = '0;
    logic eack = 0, evalid = 0, esat = 0;

    typedef struct {
        dp_cmd_t     cmd;
        logic [15:0] din;
        logic        we;
        logic [2:0]  addr;
        logic [15:0] coeff;
        logic [15:0] e_dout;
        logic        e_valid;
        logic        e_sat;
        logic        e_ack;
    } vec_t;
    vec_t tbl [$];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint wrap40(input longint v);
        longint t;
        t = v <<< 24;
        return t >>> 24;
    endfunction

    function automatic int tap_of(input dp_cmd_t cmd);
        case (cmd)
            CMD_TAP1: return 1;
            CMD_TAP2: return 2;
            CMD_TAP3: return 3;
            CMD_TAP4: return 4;
            default:  return 0;
        endcase
    endfunction

    task automatic model(input logic r, input dp_cmd_t cmd, input logic [15:0] d,
                         input logic we, input logic [2:0] a, input logic [15:0] cf);
        longint s;
        int k;
        if (!r) begin
            for (int i = 0; i < 5; i++) begin
                xm[i] = 0;
                cm[i] = 0;
            end
            accm = 0; edout = '0; eack = 0; evalid = 0; esat = 0;
        end else begin
            eack   = cmd == CMD_SHIFT;
            evalid = cmd == CMD_SAT_SH;
            esat   = 0;
            k = tap_of(cmd);
            if (cmd == CMD_SHIFT) begin
                for (int i = 4; i > 0; i--) xm[i] = xm[i-1];
                xm[0] = longint'($signed(d));
            end else if (cmd == CMD_TAP0F) begin
                accm = wrap40(xm[0] * cm[0]);
            end else if (cmd inside {CMD_TAP0, CMD_TAP1, CMD_TAP2, CMD_TAP3, CMD_TAP4}) begin
                accm = wrap40(accm + xm[k] * cm[k]);
            end else if (cmd == CMD_SAT_SH) begin
                s = accm >>> 15;
                if (s > 32767) begin
                    edout = 16'h7fff; esat = 1;
                end else if (s < -32768) begin
                    edout = 16'h8000; esat = 1;
                end else edout = 16'(s);
            end
            if (we && a < 5) cm[a] = longint'($signed(cf));
        end
    endtask

    task automatic cyc(input logic r, input dp_cmd_t cmd, input logic [15:0] d,
                       input logic we, input logic [2:0] a, input logic [15:0] cf);
        rst_n = r;
        bus.cmd_in = cmd;
        bus.din_in = d;
        bus.coeff_we_in = we;
        bus.coeff_addr_in = a;
        bus.coeff_in = cf;
        @(posedge clk);
        model(r, cmd, d, we, a, cf);
        #1;
        chk("din_ack", longint'(bus.din_ack_out), longint'(eack));
        chk("dout", longint'(bus.dout_out), longint'(edout));
        chk("dout_valid", longint'(bus.dout_valid_out), longint'(evalid));
        chk("sat", longint'(bus.sat_out), longint'(esat));
        chk("acc", longint'($signed(dut.u_mac.acc)), accm);
    endtask

    task automatic op(input dp_cmd_t cmd, input logic [15:0] d = 16'h0);
        cyc(1'b1, cmd, d, 1'b0, 3'd0, 16'h0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] cf);
        cyc(1'b1, CMD_NOP, 16'h0, 1'b1, a, cf);
    endtask

    task automatic run_fir();
        op(CMD_TAP0F);
        op(CMD_TAP1);
        op(CMD_TAP2);
        op(CMD_TAP3);
        op(CMD_TAP4);
        op(CMD_SAT_SH);
    endtask

    function automatic vec_t mk(input dp_cmd_t cmd, input logic [15:0] din, input logic we,
                                input logic [2:0] addr, input logic [15:0] coeff,
                                input logic [15:0] e_dout, input logic e_valid,
                                input logic e_sat, input logic e_ack);
        vec_t v;
        v.cmd = cmd; v.din = din; v.we = we; v.addr = addr; v.coeff = coeff;
        v.e_dout = e_dout; v.e_valid = e_valid; v.e_sat = e_sat; v.e_ack = e_ack;
        return v;
    endfunction

    initial begin
        int acks;
        dp_cmd_t rc;
        // reset held over a shift and a coefficient write
        cyc(1'b0, CMD_SHIFT, 16'h1234, 1'b1, 3'd0, 16'h5555);
        cyc(1'b0, CMD_SHIFT, 16'h1234, 1'b1, 3'd1, 16'h5555);
        for (int k = 0; k < 5; k++) begin
            chk("reset_x", longint'(dut.x[k]), 0);
            chk("reset_c", longint'(dut.c[k]), 0);
        end

        // nominal filter: c=0x4000, five samples of 100 -> 250
        for (int k = 0; k < 5; k++) tbl.push_back(mk(CMD_NOP, 16'h0, 1'b1, 3'(k), 16'h4000, 16'd0, 0, 0, 0));
        for (int k = 0; k < 5; k++) tbl.push_back(mk(CMD_SHIFT, 16'd100, 1'b0, 3'd0, 16'h0, 16'd0, 0, 0, 1));
        tbl.push_back(mk(CMD_TAP0F, 16'h0, 1'b0, 3'd0, 16'h0, 16'd0, 0, 0, 0));
        tbl.push_back(mk(CMD_TAP1, 16'h0, 1'b0, 3'd0, 16'h0, 16'd0, 0, 0, 0));
        tbl.push_back(mk(CMD_TAP2, 16'h0, 1'b0, 3'd0, 16'h0, 16'd0, 0, 0, 0));
        tbl.push_back(mk(CMD_TAP3, 16'h0, 1'b0, 3'd0, 16'h0, 16'd0, 0, 0, 0));
        tbl.push_back(mk(CMD_TAP4, 16'h0, 1'b0, 3'd0, 16'h0, 16'd0, 0, 0, 0));
        tbl.push_back(mk(CMD_SAT_SH, 16'h0, 1'b0, 3'd0, 16'h0, 16'd250, 1, 0, 0));
        tbl.push_back(mk(CMD_NOP, 16'h0, 1'b0, 3'd0, 16'h0, 16'd250, 0, 0, 0));
        tbl.push_back(mk(dp_cmd_t'(4'hb), 16'h0, 1'b1, 3'd6, 16'h1111, 16'd250, 0, 0, 0));
        acks = 0;
        foreach (tbl[i]) begin
            cyc(1'b1, tbl[i].cmd, tbl[i].din, tbl[i].we, tbl[i].addr, tbl[i].coeff);
            acks += int'(bus.din_ack_out);
            chk("tbl_dout", longint'(bus.dout_out), longint'(tbl[i].e_dout));
            chk("tbl_valid", longint'(bus.dout_valid_out), longint'(tbl[i].e_valid));
            chk("tbl_sat", longint'(bus.sat_out), longint'(tbl[i].e_sat));
            chk("tbl_ack", longint'(bus.din_ack_out), longint'(tbl[i].e_ack));
        end
        chk("ack_count", acks, 5);

        // positive saturation
        for (int k = 0; k < 5; k++) wr(3'(k), 16'h7fff);
        for (int k = 0; k < 5; k++) op(CMD_SHIFT, 16'h7fff);
        run_fir();
        chk("pos_acc", longint'($signed(dut.u_mac.acc)), 64'sd5368381445);
        chk("pos_dout", longint'(bus.dout_out), 32'h7fff);
        chk("pos_sat", longint'(bus.sat_out), 1);

        // negative saturation
        for (int k = 0; k < 5; k++) op(CMD_SHIFT, 16'h8000);
        run_fir();
        chk("neg_dout", longint'(bus.dout_out), 32'h8000);
        chk("neg_sat", longint'(bus.sat_out), 1);

        // clear versus accumulate
        cyc(1'b0, CMD_NOP, 16'h0, 1'b0, 3'd0, 16'h0);
        wr(3'd0, 16'h4000);
        op(CMD_SHIFT, 16'd100);
        op(CMD_TAP0F);
        op(CMD_TAP0);
        op(CMD_SAT_SH);
        chk("accum_dout", longint'(bus.dout_out), 100);
        op(CMD_TAP0F);
        op(CMD_SAT_SH);
        chk("clear_dout", longint'(bus.dout_out), 50);

        // coefficient write colliding with its own tap, then reset mid-sum
        wr(3'd1, 16'h4000);
        op(CMD_SHIFT, 16'd100);
        op(CMD_SHIFT, 16'd100);
        op(CMD_TAP0F);
        cyc(1'b1, CMD_TAP1, 16'h0, 1'b1, 3'd1, 16'h0);
        chk("collide_acc", longint'($signed(dut.u_mac.acc)), 3276800);
        chk("collide_c1", longint'(dut.c[1]), 0);
        op(CMD_TAP2);
        op(CMD_SAT_SH);
        cyc(1'b0, CMD_TAP3, 16'h0, 1'b1, 3'd3, 16'h7777);
        chk("midrst_acc", longint'($signed(dut.u_mac.acc)), 0);
        chk("midrst_dout", longint'(bus.dout_out), 0);
        chk("midrst_c3", longint'(dut.c[3]), 0);

        // random traffic including undefined encodings and occasional reset
        for (int i = 0; i < 600; i++) begin
            rc = dp_cmd_t'(4'($urandom_range(0, 15)));
            cyc($urandom_range(0, 63) != 0, rc, 16'($urandom), 1'($urandom),
                3'($urandom_range(0, 7)), 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
